// File: rtl/data_mem_ctrl_pkg.sv
// Shared constants, request record and load-assembly helper for the
// MEM-stage data memory controller.
package mem_pkg;

    localparam int LANE_MSB = 3;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ISSUE = 2'b01;
    localparam logic [1:0] ST_WAIT  = 2'b10;
    localparam logic [1:0] ST_RESP  = 2'b11;

    typedef struct packed {
        logic              we;
        logic [1:0]        size;
        logic              sgn;
        logic [1:0]        offset;
        logic [LANE_MSB:0] mask;
    } mem_req_t;

    // Pick the addressed byte/half out of the big-endian lane word and extend it.
    function automatic logic [31:0] assemble_load(
        input logic [1:0]  size,
        input logic        sgn,
        input logic [1:0]  offset,
        input logic [31:0] lanes
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (offset)
            2'd0:    b = lanes[31:24];
            2'd1:    b = lanes[23:16];
            2'd2:    b = lanes[15:8];
            default: b = lanes[7:0];
        endcase
        h = offset[1] ? lanes[15:0] : lanes[31:16];
        case (size)
            SIZE_BYTE: r = {{24{sgn & b[7]}}, b};
            SIZE_HALF: r = {{16{sgn & h[15]}}, h};
            default:   r = lanes;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Pipeline request/response handshake plus the byte-lane bank bus.
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 9
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic [3:0]        lane_rd_en;
    logic [3:0]        lane_wr_en;
    logic [ADDR_W-1:0] lane_addr;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_rdata;
    logic [3:0]        lane_valid;

    // Controller side.
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output lane_rd_en, lane_wr_en, lane_addr, lane_wdata,
        input  lane_rdata, lane_valid
    );

    // Pipeline and bank side.
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  lane_rd_en, lane_wr_en, lane_addr, lane_wdata,
        output lane_rdata, lane_valid
    );
endinterface

// File: rtl/data_mem_ctrl_lane_map.sv
// Combinational size/offset decode: big-endian lane mask, replicated
// store data and misalignment flag.
module mem_lane_map
    import mem_pkg::*;
(
    input  logic [1:0]        i_size,
    input  logic [1:0]        i_offset,
    input  logic [31:0]       i_wdata,
    output logic [LANE_MSB:0] o_mask,
    output logic [31:0]       o_wdata,
    output logic              o_misalign
);

    // Lane 3 carries the lowest byte address of a word.
    always_comb begin
        o_mask     = '0;
        o_wdata    = i_wdata;
        o_misalign = 1'b0;
        case (i_size)
            SIZE_BYTE: begin
                o_mask  = 4'b1000 >> i_offset;
                o_wdata = {4{i_wdata[7:0]}};
            end
            SIZE_HALF: begin
                o_mask     = i_offset[1] ? 4'b0011 : 4'b1100;
                o_wdata    = {2{i_wdata[15:0]}};
                o_misalign = i_offset[0];
            end
            SIZE_WORD: begin
                o_mask     = 4'b1111;
                o_misalign = |i_offset;
            end
            default: begin
                o_mask = '0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage access controller for four byte-lane data banks.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | ready for a request; req_ready high
// ST_ISSUE | lane strobes asserted for this single cycle
// ST_WAIT  | load only: collecting lane_valid, timeout counting down
// ST_RESP  | resp_valid pulse, then back to idle
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 8
) (
    input logic            clk,
    input logic            rst,
    data_mem_ctrl_if.slave bus
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [1:0]        r_state;
    mem_req_t          r_req;
    logic [LANE_MSB:0] r_seen;
    logic [31:0]       r_lane_buf;
    logic [TMR_W-1:0]  r_tmr;
    logic [LANE_MSB:0] r_lane_rd_en;
    logic [LANE_MSB:0] r_lane_wr_en;
    logic [ADDR_W-1:0] r_lane_addr;
    logic [31:0]       r_lane_wdata;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [31:0]       r_resp_rdata;

    logic [LANE_MSB:0] w_mask;
    logic [31:0]       w_rep_wdata;
    logic              w_misalign;
    logic              w_out_of_range;
    logic              w_req_err;
    logic              w_accept;
    logic [LANE_MSB:0] w_hit;
    logic [LANE_MSB:0] w_seen_nxt;
    logic [31:0]       w_buf_nxt;
    logic              w_done;
    logic              w_timeout;

    mem_lane_map u_lane_map (
        .i_size     (bus.req_size),
        .i_offset   (bus.req_addr[1:0]),
        .i_wdata    (bus.req_wdata),
        .o_mask     (w_mask),
        .o_wdata    (w_rep_wdata),
        .o_misalign (w_misalign)
    );

    assign w_accept       = bus.req_valid && (r_state == ST_IDLE);
    assign w_out_of_range = |bus.req_addr[31:ADDR_W+2];
    assign w_req_err      = (bus.req_size == SIZE_RSVD) || w_misalign || w_out_of_range;

    // Lanes outside the mask never contribute, whatever their valid does.
    assign w_hit      = bus.lane_valid & r_req.mask;
    assign w_seen_nxt = r_seen | w_hit;
    assign w_done     = (w_seen_nxt == r_req.mask);
    assign w_timeout  = (r_tmr == '0);

    // Merge this cycle's valid lane bytes into the capture buffer.
    always_comb begin
        w_buf_nxt = r_lane_buf;
        for (int k = 0; k <= LANE_MSB; k++) begin
            if (w_hit[k]) begin
                w_buf_nxt[8*k +: 8] = bus.lane_rdata[8*k +: 8];
            end
        end
    end

    // Access sequencing, registered lane strobes and the response pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_req        <= '0;
            r_seen       <= '0;
            r_lane_buf   <= '0;
            r_tmr        <= '0;
            r_lane_rd_en <= '0;
            r_lane_wr_en <= '0;
            r_lane_addr  <= '0;
            r_lane_wdata <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_lane_rd_en <= '0;
            r_lane_wr_en <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req <= '{we:     bus.req_we,
                                   size:   bus.req_size,
                                   sgn:    bus.req_signed,
                                   offset: bus.req_addr[1:0],
                                   mask:   w_mask};
                        if (w_req_err) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_state     <= ST_ISSUE;
                            r_lane_addr <= bus.req_addr[ADDR_W+1:2];
                            if (bus.req_we) begin
                                r_lane_wr_en <= w_mask;
                                r_lane_wdata <= w_rep_wdata;
                            end else begin
                                r_lane_rd_en <= w_mask;
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    if (r_req.we) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                    end else begin
                        r_state    <= ST_WAIT;
                        r_seen     <= '0;
                        r_lane_buf <= '0;
                        r_tmr      <= TMR_W'(TIMEOUT - 1);
                    end
                end
                ST_WAIT: begin
                    r_seen     <= w_seen_nxt;
                    r_lane_buf <= w_buf_nxt;
                    if (w_done) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= assemble_load(r_req.size, r_req.sgn,
                                                      r_req.offset, w_buf_nxt);
                    end else if (w_timeout) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.lane_rd_en = r_lane_rd_en;
    assign bus.lane_wr_en = r_lane_wr_en;
    assign bus.lane_addr  = r_lane_addr;
    assign bus.lane_wdata = r_lane_wdata;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: byte-lane bank model, directed vector table,
// timeout and reset sequences, then randomized traffic against a
// byte-addressed big-endian reference memory.
module tb_data_mem_ctrl;
    import mem_pkg::*;

    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 8;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int NBYTES  = 4 * DEPTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    data_mem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- bank model ----------------
    logic [7:0] bank [4][DEPTH];
    bit         pend_on  [4];
    int         pend_cnt [4];
    logic [7:0] pend_dat [4];
    logic [3:0] busy      = '0;
    logic [3:0] hold_off  = '0;
    bit         noise_en  = 1'b0;
    int         max_delay = 1;

    always @(posedge clk) begin
        logic       v;
        logic [7:0] d;
        if (rst) begin
            for (int k = 0; k < 4; k++) pend_on[k] = 1'b0;
            busy = '0;
            bus.lane_valid <= '0;
            bus.lane_rdata <= '0;
        end else begin
            if (bus.resp_valid) busy = '0;
            for (int k = 0; k < 4; k++) begin
                if (bus.lane_wr_en[k]) bank[k][bus.lane_addr] = bus.lane_wdata[8*k +: 8];
                if (bus.lane_rd_en[k]) begin
                    pend_on[k]  = 1'b1;
                    pend_cnt[k] = $urandom_range(max_delay, 1);
                    pend_dat[k] = bank[k][bus.lane_addr];
                    busy[k]     = 1'b1;
                end
                v = 1'b0;
                d = 8'($urandom);
                if (pend_on[k]) begin
                    pend_cnt[k] = pend_cnt[k] - 1;
                    if (pend_cnt[k] == 0) begin
                        pend_on[k] = 1'b0;
                        v = !hold_off[k];
                        d = pend_dat[k];
                    end
                end else if (noise_en && !busy[k]) begin
                    v = 1'($urandom_range(1, 0));
                end
                bus.lane_valid[k]       <= v;
                bus.lane_rdata[8*k +: 8] <= d;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [NBYTES];

    // Returns expected data/error and latency (0 = depends on bank delay).
    function automatic void ref_access(input logic we, input logic [1:0] size,
                                       input logic sgn, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [3:0] hold,
                                       output logic [31:0] rd, output logic er,
                                       output int lat);
        int unsigned n;
        int unsigned a;
        logic [31:0] v;
        n   = 32'd1 << size;
        a   = addr;
        rd  = '0;
        er  = 1'b0;
        lat = 0;
        v   = '0;
        if (size == 2'b11 || a >= NBYTES || (a % n) != 0) begin
            er  = 1'b1;
            lat = 1;
            return;
        end
        if (we) begin
            for (int unsigned i = 0; i < n; i++)
                ref_mem[a + i] = 8'(wdata >> (8 * (n - 1 - i)));
            lat = 2;
            return;
        end
        for (int unsigned i = 0; i < n; i++) begin
            if (hold[3 - ((a + i) % 4)]) er = 1'b1;
            v = (v << 8) | 32'(ref_mem[a + i]);
        end
        if (er) begin
            lat = 2 + TIMEOUT;
            return;
        end
        if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 1);
        rd = v;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0]       rd;
        logic              er;
        int                lat;
        logic [3:0]        wr;
        logic [3:0]        rdm;
        int                strobes;
        logic [31:0]       wd;
        logic [ADDR_W-1:0] la;
        bit                ready_ok;
        bit                post_ok;
    } res_t;

    // Called at a negedge; drives one request, returns at the negedge after the response.
    task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output res_t r);
        int  guard;
        bit  got;
        guard = 0;
        got   = 1'b0;
        r.rd = '0; r.er = 1'b0; r.lat = -1; r.wr = '0; r.rdm = '0;
        r.strobes = 0; r.wd = '0; r.la = '0; r.ready_ok = 1'b1; r.post_ok = 1'b0;
        while (!bus.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_wdata  = 32'($urandom);
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk);
            if (|bus.lane_rd_en || |bus.lane_wr_en) begin
                r.strobes++;
                r.wr  = r.wr | bus.lane_wr_en;
                r.rdm = r.rdm | bus.lane_rd_en;
                r.wd  = bus.lane_wdata;
                r.la  = bus.lane_addr;
            end
            if (bus.req_ready) r.ready_ok = 1'b0;
            if (bus.resp_valid) begin
                r.rd  = bus.resp_rdata;
                r.er  = bus.resp_err;
                r.lat = c;
                got   = 1'b1;
                break;
            end
        end
        if (got) begin
            @(negedge clk);
            r.post_ok = !bus.resp_valid && bus.req_ready;
        end
    endtask

    typedef struct {
        logic              we;
        logic [1:0]        size;
        logic              sgn;
        logic [31:0]       addr;
        logic [31:0]       wdata;
        logic [31:0]       exp_rd;
        logic              exp_err;
        int                exp_lat;
        logic [3:0]        exp_wr;
        logic [3:0]        exp_rdm;
        logic [31:0]       exp_wd;
        logic [ADDR_W-1:0] exp_la;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rd, input logic exp_err,
                                input int exp_lat, input logic [3:0] exp_wr,
                                input logic [3:0] exp_rdm, input logic [31:0] exp_wd,
                                input logic [ADDR_W-1:0] exp_la);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat;
        v.exp_wr = exp_wr; v.exp_rdm = exp_rdm; v.exp_wd = exp_wd; v.exp_la = exp_la;
        return v;
    endfunction

    task automatic check_vec(input string tag, input vec_t v, input res_t r);
        chk({tag, "_rdata"}, r.rd, v.exp_rd);
        chk({tag, "_err"}, 32'(r.er), 32'(v.exp_err));
        chk({tag, "_lat"}, 32'(r.lat), 32'(v.exp_lat));
        chk({tag, "_wr_en"}, 32'(r.wr), 32'(v.exp_wr));
        chk({tag, "_rd_en"}, 32'(r.rdm), 32'(v.exp_rdm));
        chk({tag, "_strobe_cycles"}, 32'(r.strobes), v.exp_err ? 32'd0 : 32'd1);
        if (!v.exp_err) chk({tag, "_lane_addr"}, 32'(r.la), 32'(v.exp_la));
        if (!v.exp_err && v.we) chk({tag, "_lane_wdata"}, r.wd, v.exp_wd);
        chk({tag, "_ready_low"}, 32'(r.ready_ok), 32'd1);
        chk({tag, "_one_pulse"}, 32'(r.post_ok), 32'd1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    vec_t vecs [19];

    initial begin
        res_t        r;
        logic [31:0] m_rd;
        logic        m_er;
        int          m_lat;
        int          resp_seen;

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;

        for (int i = 0; i < NBYTES; i++) begin
            ref_mem[i] = 8'($urandom);
            bank[3 - (i % 4)][i / 4] = ref_mem[i];
        end

        //        we  sz    s  addr        wdata         exp_rd        err lat wr     rd     wd            la
        vecs[0]  = mk(1, 2'b10, 0, 32'h7F0, 32'hDEADBEEF, 32'h0,        0, 2, 4'hF, 4'h0, 32'hDEADBEEF, 9'h1FC);
        vecs[1]  = mk(0, 2'b00, 1, 32'h7F0, 32'h0,        32'hFFFFFFDE, 0, 3, 4'h0, 4'h8, 32'h0,        9'h1FC);
        vecs[2]  = mk(0, 2'b00, 0, 32'h7F3, 32'h0,        32'h000000EF, 0, 3, 4'h0, 4'h1, 32'h0,        9'h1FC);
        vecs[3]  = mk(0, 2'b01, 1, 32'h7F2, 32'h0,        32'hFFFFBEEF, 0, 3, 4'h0, 4'h3, 32'h0,        9'h1FC);
        vecs[4]  = mk(0, 2'b01, 0, 32'h7F0, 32'h0,        32'h0000DEAD, 0, 3, 4'h0, 4'hC, 32'h0,        9'h1FC);
        vecs[5]  = mk(1, 2'b00, 0, 32'h7F1, 32'h00000055, 32'h0,        0, 2, 4'h4, 4'h0, 32'h55555555, 9'h1FC);
        vecs[6]  = mk(0, 2'b10, 0, 32'h7F0, 32'h0,        32'hDE55BEEF, 0, 3, 4'h0, 4'hF, 32'h0,        9'h1FC);
        vecs[7]  = mk(0, 2'b00, 1, 32'h7F1, 32'h0,        32'h00000055, 0, 3, 4'h0, 4'h4, 32'h0,        9'h1FC);
        vecs[8]  = mk(0, 2'b10, 0, 32'h7F2, 32'h0,        32'h0,        1, 1, 4'h0, 4'h0, 32'h0,        9'h0);
        vecs[9]  = mk(0, 2'b01, 0, 32'h7F1, 32'h0,        32'h0,        1, 1, 4'h0, 4'h0, 32'h0,        9'h0);
        vecs[10] = mk(0, 2'b11, 0, 32'h7F0, 32'h0,        32'h0,        1, 1, 4'h0, 4'h0, 32'h0,        9'h0);
        vecs[11] = mk(0, 2'b10, 0, 32'h800, 32'h0,        32'h0,        1, 1, 4'h0, 4'h0, 32'h0,        9'h0);
        vecs[12] = mk(1, 2'b10, 0, 32'h7F2, 32'h12345678, 32'h0,        1, 1, 4'h0, 4'h0, 32'h0,        9'h0);
        vecs[13] = mk(0, 2'b10, 0, 32'h7F0, 32'h0,        32'hDE55BEEF, 0, 3, 4'h0, 4'hF, 32'h0,        9'h1FC);
        vecs[14] = mk(1, 2'b01, 0, 32'h002, 32'hCAFEA5B6, 32'h0,        0, 2, 4'h3, 4'h0, 32'hA5B6A5B6, 9'h000);
        vecs[15] = mk(0, 2'b01, 1, 32'h002, 32'h0,        32'hFFFFA5B6, 0, 3, 4'h0, 4'h3, 32'h0,        9'h000);
        vecs[16] = mk(0, 2'b00, 0, 32'h002, 32'h0,        32'h000000A5, 0, 3, 4'h0, 4'h2, 32'h0,        9'h000);
        vecs[17] = mk(0, 2'b00, 1, 32'h003, 32'h0,        32'hFFFFFFB6, 0, 3, 4'h0, 4'h1, 32'h0,        9'h000);
        vecs[18] = mk(0, 2'b10, 1, 32'h7F0, 32'h0,        32'hDE55BEEF, 0, 3, 4'h0, 4'hF, 32'h0,        9'h1FC);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("reset_strobes", 32'({bus.lane_rd_en, bus.lane_wr_en}), 32'd0);
        chk("reset_lane_addr", 32'(bus.lane_addr), 32'd0);
        chk("reset_lane_wdata", bus.lane_wdata, 32'd0);

        // Directed table; bank noise on lanes not being read must be ignored.
        noise_en  = 1'b1;
        max_delay = 1;
        for (int i = 0; i < 19; i++) begin
            run_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, r);
            ref_access(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                       4'h0, m_rd, m_er, m_lat);
            check_vec($sformatf("vec%0d", i), vecs[i], r);
        end

        // Timeout: lane 1 never answers.
        hold_off = 4'b0010;
        run_req(1'b0, SIZE_WORD, 1'b0, 32'h7F0, 32'h0, r);
        chk("timeout_err", 32'(r.er), 32'd1);
        chk("timeout_rdata", r.rd, 32'd0);
        chk("timeout_lat", 32'(r.lat), 32'(2 + TIMEOUT));
        chk("timeout_ready_low", 32'(r.ready_ok), 32'd1);
        chk("timeout_rd_en", 32'(r.rdm), 32'hF);

        // Reset while waiting on the held lane.
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_size   = SIZE_WORD;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h7F0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_ready_low", 32'(bus.req_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_wait_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_wait_resp", 32'({bus.resp_valid, bus.resp_err}), 32'd0);
        chk("rst_wait_rdata", bus.resp_rdata, 32'd0);
        chk("rst_wait_strobes", 32'({bus.lane_rd_en, bus.lane_wr_en}), 32'd0);
        chk("rst_wait_lane_addr", 32'(bus.lane_addr), 32'd0);
        chk("rst_wait_lane_wdata", bus.lane_wdata, 32'd0);
        rst      = 1'b0;
        hold_off = 4'b0000;
        resp_seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.resp_valid) resp_seen++;
        end
        chk("rst_no_resp", 32'(resp_seen), 32'd0);
        run_req(1'b1, SIZE_WORD, 1'b0, 32'h100, 32'h0BADF00D, r);
        ref_access(1'b1, SIZE_WORD, 1'b0, 32'h100, 32'h0BADF00D, 4'h0, m_rd, m_er, m_lat);
        chk("post_rst_sw_lat", 32'(r.lat), 32'd2);
        chk("post_rst_sw_err", 32'(r.er), 32'd0);
        run_req(1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0, r);
        chk("post_rst_lw_rdata", r.rd, 32'h0BADF00D);
        chk("post_rst_lw_lat", 32'(r.lat), 32'd3);

        // Randomized traffic with jittered bank latency.
        max_delay = 3;
        for (int i = 0; i < 400; i++) begin
            logic        we, sgn;
            logic [1:0]  size;
            logic [31:0] addr, wdata;
            logic [3:0]  hold;
            int unsigned sel;
            we    = 1'($urandom_range(1, 0));
            sgn   = 1'($urandom_range(1, 0));
            size  = ($urandom_range(15, 0) == 0) ? 2'b11 : 2'($urandom_range(2, 0));
            wdata = $urandom;
            sel   = $urandom_range(9, 0);
            if (sel == 0)      addr = $urandom;
            else if (sel < 5)  addr = 32'($urandom_range(63, 0));
            else               addr = 32'($urandom_range(NBYTES - 1, 0));
            if (sel > 2 && size != 2'b11) addr = addr & ~((32'd1 << size) - 1);
            hold = '0;
            if (!we && $urandom_range(9, 0) == 0) hold = 4'b0001 << $urandom_range(3, 0);
            hold_off = hold;
            ref_access(we, size, sgn, addr, wdata, hold, m_rd, m_er, m_lat);
            run_req(we, size, sgn, addr, wdata, r);
            chk($sformatf("rand%0d_rdata", i), r.rd, m_rd);
            chk($sformatf("rand%0d_err", i), 32'(r.er), 32'(m_er));
            if (m_lat != 0) chk($sformatf("rand%0d_lat", i), 32'(r.lat), 32'(m_lat));
            else            chk($sformatf("rand%0d_resp", i), 32'(r.lat >= 3 && r.lat <= 5), 32'd1);
        end
        hold_off = '0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
